ss_scan_ctrl: RTL

Time-multiplexed scan controller for the 8-digit seven-segment display on the board. It holds a 32-bit display value (eight hex nibbles), selects one nibble per slot onto the `ss_display` decoder's `Din`, drives that decoder's `AN_5` input to control the decimal point, and drives the active-low digit anodes. A blanking gap between slots prevents ghosting. New values arrive through a valid/ready handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/ss_scan_ctrl_if.sv | 22 ++
 rtl/ss_scan_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ss_scan_ctrl_if.sv
// Handshake, control and display-drive signals of the seven-segment scan controller.
interface ss_scan_ctrl_if;
  logic        enable;
  logic [31:0] value;
  logic        value_vld;
  logic        value_rdy;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [3:0]  digit;
  logic        dp_sel;
  logic        frame_done;

  modport slave (
    input  enable, value, value_vld, dp_mask,
    output value_rdy, an, digit, dp_sel, frame_done
  );

  modport master (
    output enable, value, value_vld, dp_mask,
    input  value_rdy, an, digit, dp_sel, frame_done
  );
endinterface

// File: rtl/ss_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with frame-aligned value updates.
// Define SS_LZ_BLANK_EN to enable leading-zero suppression.
module ss_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input logic          clk,
  input logic          rst,
  ss_scan_ctrl_if.slave bus
);

  localparam int unsigned MaxCyc = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e            r_state, w_state_d;
  logic [2:0]        r_idx, w_idx_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [31:0]       r_disp, w_disp_d;
  logic [31:0]       r_shadow, w_shadow_d;
  logic              r_full, w_full_d;
  logic              r_xfer, w_xfer;
  logic              w_boundary;
  logic              w_lit;
  logic [7:0]        r_an, w_an_d;
  logic [3:0]        r_digit, w_digit_d;
  logic              r_dp_sel, w_dp_sel_d;
  logic              r_frame_done, w_frame_done_d;

  // Scan sequencing.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    if (!bus.enable) begin
      w_state_d = StIdle;
      w_idx_d   = 3'd0;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StBlank;
          w_idx_d   = 3'd0;
          w_cnt_d   = '0;
        end
        StBlank: begin
          if (r_cnt == BlankLast) begin
            w_state_d = StShow;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StShow: begin
          if (r_cnt == ShowLast) begin
            w_state_d = StBlank;
            w_idx_d   = r_idx + 3'd1;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_idx_d   = 3'd0;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  // Shadow handshake; full drops one cycle after the shadow moves into disp.
  always_comb begin
    w_boundary = (r_state == StIdle) ||
                 ((r_state == StShow) && (r_idx == 3'd7) && (r_cnt == ShowLast));
    w_xfer     = w_boundary && r_full && !r_xfer;
    w_disp_d   = w_xfer ? r_shadow : r_disp;
    w_shadow_d = r_shadow;
    w_full_d   = r_full;
    if (r_xfer) begin
      w_full_d = 1'b0;
    end else if (!r_full && bus.value_vld) begin
      w_shadow_d = bus.value;
      w_full_d   = 1'b1;
    end
  end

  // Outputs are computed from next-state values so they can be registered.
  always_comb begin
    w_lit = 1'b1;
`ifdef SS_LZ_BLANK_EN
    w_lit = (w_idx_d == 3'd0) || ((w_disp_d >> {w_idx_d, 2'b00}) != 32'd0);
`endif
    w_an_d     = 8'hFF;
    w_dp_sel_d = 1'b1;
    if ((w_state_d == StShow) && w_lit) begin
      w_an_d     = ~(8'd1 << w_idx_d);
      w_dp_sel_d = ~bus.dp_mask[w_idx_d];
    end
    w_digit_d      = w_disp_d[{w_idx_d, 2'b00} +: 4];
    w_frame_done_d = (w_state_d == StShow) && (w_idx_d == 3'd7) && (w_cnt_d == ShowLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_idx        <= 3'd0;
      r_cnt        <= '0;
      r_disp       <= 32'd0;
      r_shadow     <= 32'd0;
      r_full       <= 1'b0;
      r_xfer       <= 1'b0;
      r_an         <= 8'hFF;
      r_digit      <= 4'd0;
      r_dp_sel     <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_idx        <= w_idx_d;
      r_cnt        <= w_cnt_d;
      r_disp       <= w_disp_d;
      r_shadow     <= w_shadow_d;
      r_full       <= w_full_d;
      r_xfer       <= w_xfer;
      r_an         <= w_an_d;
      r_digit      <= w_digit_d;
      r_dp_sel     <= w_dp_sel_d;
      r_frame_done <= w_frame_done_d;
    end
  end

  assign bus.value_rdy  = ~r_full;
  assign bus.an         = r_an;
  assign bus.digit      = r_digit;
  assign bus.dp_sel     = r_dp_sel;
  assign bus.frame_done = r_frame_done;

endmodule
